// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: walks every address of a sync-read block RAM once to fill it with a
// seeded pattern, checksum its contents, or checksum and verify them against the pattern.
module mem_sweep_ctrl #(
  parameter int unsigned WID_MEM   = 2,
  parameter int unsigned DEPTH_MEM = 16384,
  localparam int unsigned AW       = $clog2(DEPTH_MEM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WID_MEM-1:0] seed,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      mem_raddr,
  output logic [AW-1:0]      mem_waddr,
  output logic               mem_we,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic [31:0]        checksum,
  output logic [AW:0]        err_count,
  output logic               err_seen,
  output logic [AW-1:0]      first_err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_addr;
  logic [AW-1:0]        w_addr_nxt;
  logic [WID_MEM-1:0]   r_seed;
  logic [WID_MEM-1:0]   w_seed_nxt;
  logic                 r_verify;
  logic                 r_rd_valid;
  logic [AW-1:0]        r_rd_addr;
  logic                 w_accept;
  logic                 w_kill;
  logic                 w_acc;
  logic                 w_busy_nxt;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_we;
  logic [AW-1:0]        r_waddr;
  logic [AW-1:0]        r_raddr;
  logic [WID_MEM-1:0]   r_din;
  logic [31:0]          r_checksum;
  logic [AW:0]          r_err_count;
  logic                 r_err_seen;
  logic [AW-1:0]        r_first_err_addr;

  // Pattern word for an address: low address bits (zero-extended if narrower) xor seed
  function automatic logic [WID_MEM-1:0] f_pattern(input logic [AW-1:0] a,
                                                   input logic [WID_MEM-1:0] s);
    return WID_MEM'(a) ^ s;
  endfunction

  // Next-state, address and command-acceptance logic
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_accept    = 1'b0;
    w_kill      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_addr_nxt = '0;
          unique case (mode)
            2'b01:   w_state_nxt = S_FILL;
            2'b11:   w_state_nxt = S_DONE;
            default: w_state_nxt = S_SCAN;
          endcase
        end
      end
      S_FILL: begin
        if (abort) begin
          w_kill      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_addr_nxt = r_addr + AW'(1);
          if (r_addr == LAST_ADDR) w_state_nxt = S_DONE;
        end
      end
      S_SCAN: begin
        if (abort) begin
          w_kill      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_addr_nxt = r_addr + AW'(1);
          if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_kill      = abort;
        w_state_nxt = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_seed_nxt = w_accept ? seed : r_seed;
  assign w_acc      = r_rd_valid && !w_kill;
  assign w_busy_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_SCAN) ||
                      (w_state_nxt == S_DRAIN);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sweep address, latched command and read-return tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_seed     <= '0;
      r_verify   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_seed     <= w_seed_nxt;
      if (w_accept) r_verify <= (mode == 2'b10);
      r_rd_valid <= (r_state == S_SCAN) && !abort;
      r_rd_addr  <= r_addr;
    end
  end

  // Registered RAM-port and status outputs, driven from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_din   <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      r_we    <= (w_state_nxt == S_FILL);
      r_waddr <= (w_state_nxt == S_FILL) ? w_addr_nxt : '0;
      r_din   <= (w_state_nxt == S_FILL) ? f_pattern(w_addr_nxt, w_seed_nxt) : '0;
      r_raddr <= (w_state_nxt == S_SCAN) ? w_addr_nxt : '0;
    end
  end

  // Checksum and mismatch accumulation on each qualified read word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum       <= '0;
      r_err_count      <= '0;
      r_err_seen       <= 1'b0;
      r_first_err_addr <= '0;
    end else if (w_accept) begin
      r_checksum       <= '0;
      r_err_count      <= '0;
      r_err_seen       <= 1'b0;
      r_first_err_addr <= '0;
    end else if (w_acc) begin
      r_checksum <= r_checksum + 32'(mem_dout);
      if (r_verify && (mem_dout != f_pattern(r_rd_addr, r_seed))) begin
        r_err_count <= r_err_count + (AW+1)'(1);
        if (!r_err_seen) begin
          r_first_err_addr <= r_rd_addr;
          r_err_seen       <= 1'b1;
        end
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_we         = r_we;
  assign mem_waddr      = r_waddr;
  assign mem_raddr      = r_raddr;
  assign mem_din        = r_din;
  assign checksum       = r_checksum;
  assign err_count      = r_err_count;
  assign err_seen       = r_err_seen;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Testbench for mem_sweep_ctrl with a small behavioural RAM and a reference model.
module tb_mem_sweep_ctrl;

  localparam int unsigned WID   = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      mode;
  logic [WID-1:0]  seed;
  logic            abort;
  logic            busy;
  logic            done;
  logic [AW-1:0]   mem_raddr;
  logic [AW-1:0]   mem_waddr;
  logic            mem_we;
  logic [WID-1:0]  mem_din;
  logic [WID-1:0]  mem_dout;
  logic [31:0]     checksum;
  logic [AW:0]     err_count;
  logic            err_seen;
  logic [AW-1:0]   first_err_addr;

  logic            poke_en;
  logic [AW-1:0]   poke_addr;
  logic [WID-1:0]  poke_data;
  logic [WID-1:0]  ram [DEPTH];
  int              wr_cnt;
  int              n_vec;
  int              n_err;

  mem_sweep_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .start(start), .mode(mode), .seed(seed), .abort(abort),
    .busy(busy), .done(done), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout), .checksum(checksum),
    .err_count(err_count), .err_seen(err_seen), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Simple-dual-port RAM, 1-cycle read latency, with a bench back door for corruption
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_we) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
    if (mem_we) wr_cnt = wr_cnt + 1;
  end

  function automatic logic [WID-1:0] pat(input int a, input logic [WID-1:0] s);
    return WID'(a) ^ s;
  endfunction

  function automatic int unsigned model_sum(input int last);
    int unsigned acc = 0;
    for (int a = 0; a <= last; a++) acc += int'(ram[a]);
    return acc;
  endfunction

  task automatic model_verify(input logic [WID-1:0] s, output int cnt, output int first,
                              output logic seen);
    cnt = 0; first = 0; seen = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      if (ram[a] != pat(a, s)) begin
        if (!seen) first = a;
        seen = 1'b1;
        cnt++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic poke(input int a, input logic [WID-1:0] d);
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = d;
    cyc();
    poke_en = 1'b0;
  endtask

  // Issue one command and measure done cycle, busy cycles and RAM writes
  task automatic run_cmd(input logic [1:0] m, input logic [WID-1:0] s,
                         output int done_cyc, output int busy_cyc, output int wr);
    int w0;
    w0 = wr_cnt;
    mode = m; seed = s; start = 1'b1;
    cyc();
    start = 1'b0;
    done_cyc = -1; busy_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin done_cyc = c; break; end
      if (busy) busy_cyc++;
      cyc();
    end
    n_vec++;
    if (done_cyc < 0) begin
      n_err++;
      $display("FAIL done_timeout mode=%0d: no done within 60 cycles", m);
    end else begin
      cyc();
      n_vec++;
      if (done !== 1'b0) begin
        n_err++; $display("FAIL done_pulse_width: done=%b, required 0", done);
      end
    end
    wr = wr_cnt - w0;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    int w0;
    bit hit;
    rst_n = 1'b0;
    #23;
    n_vec++;
    if ({busy, done, mem_we, mem_raddr, mem_waddr, mem_din, checksum, err_count,
         err_seen, first_err_addr} !== '0) begin
      n_err++; $display("FAIL reset_outputs: some output nonzero busy=%b we=%b", busy, mem_we);
    end
    rst_n = 1'b1;
    cyc();
    mode = 2'b01; seed = 2'b10; start = 1'b1;
    cyc();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_we && mem_waddr == AW'(5)) begin hit = 1'b1; break; end
      cyc();
    end
    chk("reset_reach_addr5", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_we, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_midfill_async: we/busy/done=%b, expected 000", {mem_we, busy, done});
    end
    w0 = wr_cnt;
    cyc(); cyc();
    #3 rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("reset_no_more_writes", wr_cnt - w0, 0);
    chk("reset_idle_busy", int'(busy), 0);
  endtask

  task automatic test_fill_scan();
    int dc, bc, wr, bad;
    logic [WID-1:0] s;
    run_cmd(2'b01, 2'b01, dc, bc, wr);
    chk("fill_done_cycle", dc, DEPTH + 1);
    chk("fill_busy_cycles", bc, DEPTH);
    chk("fill_writes", wr, DEPTH);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== pat(a, 2'b01)) bad++;
    chk("fill_contents", bad, 0);
    run_cmd(2'b00, 2'b00, dc, bc, wr);
    chk("scan_done_cycle", dc, DEPTH + 2);
    chk("scan_busy_cycles", bc, DEPTH + 1);
    chk("scan_checksum_seed1", checksum, 24);
    chk("scan_writes", wr, 0);
    for (int it = 0; it < 3; it++) begin
      s = WID'($urandom_range(0, 3));
      run_cmd(2'b01, s, dc, bc, wr);
      bad = 0;
      for (int a = 0; a < DEPTH; a++) if (ram[a] !== pat(a, s)) bad++;
      chk("rand_fill_contents", bad, 0);
      run_cmd(2'b00, WID'($urandom_range(0, 3)), dc, bc, wr);
      chk("rand_scan_checksum", checksum, model_sum(DEPTH - 1));
      chk("rand_scan_err_count", err_count, 0);
    end
  endtask

  task automatic test_verify();
    int dc, bc, wr, ecnt, efirst;
    logic eseen;
    logic [WID-1:0] s;
    run_cmd(2'b01, 2'b01, dc, bc, wr);
    run_cmd(2'b10, 2'b01, dc, bc, wr);
    chk("verify_clean_done", dc, DEPTH + 2);
    chk("verify_clean_err", err_count, 0);
    chk("verify_clean_seen", err_seen, 0);
    chk("verify_clean_sum", checksum, 24);
    poke(3, 2'b00);
    poke(9, 2'b11);
    run_cmd(2'b10, 2'b01, dc, bc, wr);
    chk("verify_corrupt_err", err_count, 2);
    chk("verify_corrupt_first", first_err_addr, 3);
    chk("verify_corrupt_seen", err_seen, 1);
    chk("verify_corrupt_sum", checksum, model_sum(DEPTH - 1));
    for (int it = 0; it < 4; it++) begin
      s = WID'($urandom_range(0, 3));
      run_cmd(2'b01, s, dc, bc, wr);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        poke(int'($urandom_range(0, DEPTH - 1)), WID'($urandom_range(0, 3)));
      if (it == 3) s = s ^ 2'b01;
      run_cmd(2'b10, s, dc, bc, wr);
      model_verify(s, ecnt, efirst, eseen);
      chk("rand_verify_err", err_count, ecnt);
      chk("rand_verify_seen", err_seen, eseen);
      chk("rand_verify_first", first_err_addr, efirst);
      chk("rand_verify_sum", checksum, model_sum(DEPTH - 1));
    end
  endtask

  task automatic test_ignored_start();
    int dc, bc, wr, w0, rd_seen;
    w0 = wr_cnt;
    mode = 2'b00; seed = 2'b00; start = 1'b1;
    cyc();
    start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      start = (c == 5);
      if (c == 5) mode = 2'b01;
      if (done) begin dc = c; break; end
      cyc();
    end
    start = 1'b0;
    chk("busy_start_done_cycle", dc, DEPTH + 2);
    chk("busy_start_writes", wr_cnt - w0, 0);
    cyc(); cyc();
    chk("busy_start_not_queued", int'(busy), 0);
    chk("busy_start_sum", checksum, model_sum(DEPTH - 1));
    // Reserved mode: immediate done, cleared results, no RAM activity
    w0 = wr_cnt;
    mode = 2'b11; seed = WID'($urandom_range(0, 3)); start = 1'b1;
    cyc();
    start = 1'b0;
    chk("mode11_done_cycle1", int'(done), 1);
    chk("mode11_busy", int'(busy), 0);
    chk("mode11_sum", checksum, 0);
    chk("mode11_err", err_count, 0);
    rd_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_raddr != '0 || busy) rd_seen++;
      cyc();
    end
    chk("mode11_no_access", rd_seen + (wr_cnt - w0), 0);
  endtask

  task automatic test_abort();
    int dc, bc, wr, dcount;
    bit hit;
    logic [31:0] held;
    run_cmd(2'b01, WID'($urandom_range(0, 3)), dc, bc, wr);
    mode = 2'b00; start = 1'b1;
    cyc();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy && mem_raddr == AW'(7)) begin hit = 1'b1; break; end
      cyc();
    end
    chk("abort_reach_addr7", int'(hit), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy_low", int'(busy), 0);
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) dcount++;
      cyc();
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_partial_sum", checksum, model_sum(5));
    held = checksum;
    abort = 1'b1;
    cyc(); cyc();
    abort = 1'b0;
    chk("abort_idle_noeffect", checksum, held);
    // start and abort together in IDLE: start is taken
    mode = 2'b11; abort = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_together", int'(done), 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; wr_cnt = 0;
    start = 1'b0; mode = 2'b00; seed = '0; abort = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    test_reset();
    test_fill_scan();
    test_verify();
    test_ignored_start();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
